// File: rtl/gpu_copy_ctrl_pkg.sv
// Shared types and constants for the GPU rect-table copy controller.
package gpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GPU_RST,
        START,
        COPY,
        FINISH
    } ctrl_state_t;

    localparam int RECT_WORDS  = 5;
    localparam int SLOT_CYCLES = 6;

    localparam int W_X     = 0;
    localparam int W_Y     = 1;
    localparam int W_W     = 2;
    localparam int W_H     = 3;
    localparam int W_COLOR = 4;

endpackage

// File: rtl/gpu_copy_ctrl_if.sv
// Data-memory read port and GPU load port driven by the copy controller.
interface gpu_copy_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_dout;
    logic                  gpu_reset;
    logic                  gpu_copy_start;
    logic [15:0]           gpu_mem_din;

    modport master (
        output mem_rd, mem_addr, gpu_reset, gpu_copy_start, gpu_mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_rd, mem_addr, gpu_reset, gpu_copy_start, gpu_mem_din,
        output mem_dout
    );
endinterface

// File: rtl/gpu_copy_ctrl_rect_word_counter.sv
// Word-in-slot and rect counters for the copy phase; cleared whenever not enabled.
module rect_word_counter
    import gpu_ctrl_pkg::*;
#(
    parameter  int RECT_COUNT = 64,
    localparam int RW         = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1
) (
    input  logic          pixel_clk,
    input  logic          reset,
    input  logic          en,
    output logic [2:0]    word,
    output logic [RW-1:0] rect,
    output logic          last_word
);
    logic slot_end;

    assign slot_end  = (word == 3'(SLOT_CYCLES - 1));
    assign last_word = slot_end && (rect == RW'(RECT_COUNT - 1));

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            word <= '0;
            rect <= '0;
        end else if (!en) begin
            word <= '0;
            rect <= '0;
        end else if (slot_end) begin
            word <= '0;
            rect <= rect + 1'b1;
        end else begin
            word <= word + 1'b1;
        end
    end
endmodule

// File: rtl/gpu_copy_ctrl.sv
// Per-frame copy of the rect table from data memory into the GPU during vertical blank.
module gpu_copy_ctrl
    import gpu_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          ADDR_WIDTH = 13,
    parameter int          RECT_COUNT = 64
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       frame_start,
    gpu_copy_if.master bus,
    output logic       cpu_stall,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    localparam int RW = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;

    ctrl_state_t           state;
    logic [2:0]            word;
    logic [RW-1:0]         rect;
    logic                  last_word;
    logic                  rd_c;
    logic                  vld_p1;
    logic                  gpu_reset_q;
    logic                  copy_start_q;
    logic [ADDR_WIDTH-1:0] addr_c;

    rect_word_counter #(
        .RECT_COUNT(RECT_COUNT)
    ) u_counter (
        .pixel_clk(pixel_clk),
        .reset    (reset),
        .en       (state == COPY),
        .word     (word),
        .rect     (rect),
        .last_word(last_word)
    );

    // Slot cycles 0..4 issue reads; slot cycle 5 is idle so the data lands in cycles 1..5.
    assign rd_c   = (state == COPY) && (word <= 3'(W_COLOR));
    assign addr_c = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rect) * ADDR_WIDTH'(RECT_WORDS)
                  + ADDR_WIDTH'(word);

    assign bus.mem_rd         = rd_c;
    assign bus.mem_addr       = rd_c ? addr_c : '0;
    assign bus.gpu_mem_din    = vld_p1 ? bus.mem_dout : 16'h0000;
    assign bus.gpu_reset      = gpu_reset_q;
    assign bus.gpu_copy_start = copy_start_q;
    assign cpu_stall          = busy;

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gpu_reset_q  <= 1'b1;
            copy_start_q <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            gpu_reset_q  <= 1'b0;
            copy_start_q <= 1'b0;
            done         <= 1'b0;
            vld_p1       <= rd_c;
            // FINISH still counts as busy, so a pulse there is an overrun, not a restart.
            if (frame_start && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= GPU_RST;
                        gpu_reset_q <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                GPU_RST: begin
                    state        <= START;
                    copy_start_q <= 1'b1;
                end
                START: state <= COPY;
                COPY: begin
                    if (last_word) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_copy_ctrl.sv
// Randomized bench for gpu_copy_ctrl checked cycle by cycle against a timeline model.
module tb_gpu_copy_ctrl;
    localparam int AW     = 13;
    localparam int BASE_A = 32'h100;
    localparam int N_A    = 64;
    localparam int BASE_B = 32'h1FFE;
    localparam int N_B    = 2;

    logic pixel_clk   = 1'b0;
    logic reset       = 1'b1;
    logic frame_start = 1'b0;
    logic stall_a, busy_a, done_a, ovr_a;
    logic stall_b, busy_b, done_b, ovr_b;

    gpu_copy_if #(.ADDR_WIDTH(AW)) bus_a ();
    gpu_copy_if #(.ADDR_WIDTH(AW)) bus_b ();

    gpu_copy_ctrl #(.BASE_ADDR(BASE_A), .ADDR_WIDTH(AW), .RECT_COUNT(N_A)) dut_a (
        .pixel_clk(pixel_clk), .reset(reset), .frame_start(frame_start), .bus(bus_a),
        .cpu_stall(stall_a), .busy(busy_a), .done(done_a), .overrun(ovr_a));

    gpu_copy_ctrl #(.BASE_ADDR(BASE_B), .ADDR_WIDTH(AW), .RECT_COUNT(N_B)) dut_b (
        .pixel_clk(pixel_clk), .reset(reset), .frame_start(frame_start), .bus(bus_b),
        .cpu_stall(stall_b), .busy(busy_b), .done(done_b), .overrun(ovr_b));

    always #5 pixel_clk = ~pixel_clk;

    // Data memory: word i holds i, one-cycle read latency on each port.
    logic [15:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i);
    always @(posedge pixel_clk) if (bus_a.mem_rd) bus_a.mem_dout <= mem[bus_a.mem_addr];
    always @(posedge pixel_clk) if (bus_b.mem_rd) bus_b.mem_dout <= mem[bus_b.mem_addr];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference timeline: a copy accepted at cycle r resets the gpu at r, starts at r+1.
    bit in_rst = 1'b1;
    bit act_a, act_b, ov_a, ov_b;
    int r_a, r_b;

    function automatic bit busy_at(input bit act, input int r, input int n, input int c);
        return act && c >= r && c <= r + 2 + 6 * n;
    endfunction

    function automatic int addr_of(input int base, input int rect, input int k);
        return (base + 5 * rect + k) % (1 << AW);
    endfunction

    function automatic void model(input bit act, input int r, input int n, input int base,
                                  input bit ov, input int c, output logic [5:0] ctrl,
                                  output logic [31:0] rd, output logic [31:0] din);
        int t, d;
        ctrl = {5'b0, ov};
        rd   = 0;
        din  = 0;
        if (act) begin
            t = r + 1;
            d = c - t;
            ctrl[5] = (c == r);
            ctrl[4] = (c == t);
            ctrl[3] = (c >= r) && (c <= t + 6 * n + 1);
            ctrl[2] = ctrl[3];
            ctrl[1] = (c == t + 6 * n + 1);
            if (d >= 1 && d <= 6 * n && (d - 1) % 6 < 5)
                rd = 32'h10000 | 32'(addr_of(base, (d - 1) / 6, (d - 1) % 6));
            if (d >= 2 && d <= 6 * n + 1 && (d - 2) % 6 < 5)
                din = 32'(mem[addr_of(base, (d - 2) / 6, (d - 2) % 6)]);
        end
    endfunction

    always @(posedge pixel_clk) begin
        if (!reset) begin
            in_rst = 1'b1;
            act_a = 1'b0; ov_a = 1'b0;
            act_b = 1'b0; ov_b = 1'b0;
        end else begin
            in_rst = 1'b0;
            if (frame_start) begin
                if (busy_at(act_a, r_a, N_A, cyc)) ov_a = 1'b1;
                else begin act_a = 1'b1; r_a = cyc + 1; end
                if (busy_at(act_b, r_b, N_B, cyc)) ov_b = 1'b1;
                else begin act_b = 1'b1; r_b = cyc + 1; end
            end
        end
        cyc++;
    end

    always @(negedge pixel_clk) begin
        logic [5:0]  eca, ecb;
        logic [31:0] era, erb, eda, edb;
        if (!reset || in_rst) begin
            eca = 6'b100000; ecb = 6'b100000;
            era = 0; erb = 0; eda = 0; edb = 0;
        end else begin
            model(act_a, r_a, N_A, BASE_A, ov_a, cyc, eca, era, eda);
            model(act_b, r_b, N_B, BASE_B, ov_b, cyc, ecb, erb, edb);
        end
        chk("a_ctrl", 32'({bus_a.gpu_reset, bus_a.gpu_copy_start, stall_a, busy_a, done_a, ovr_a}), 32'(eca));
        chk("a_rd", {15'b0, bus_a.mem_rd, 3'b0, bus_a.mem_addr}, era);
        chk("a_din", 32'(bus_a.gpu_mem_din), eda);
        chk("b_ctrl", 32'({bus_b.gpu_reset, bus_b.gpu_copy_start, stall_b, busy_b, done_b, ovr_b}), 32'(ecb));
        chk("b_rd", {15'b0, bus_b.mem_rd, 3'b0, bus_b.mem_addr}, erb);
        chk("b_din", 32'(bus_b.gpu_mem_din), edb);
    end

    // Minimal gpu: loads 5*N_A words on the documented delivery cycles, then executes.
    localparam int G_RESET = 1, G_LOAD = 2, G_EXEC = 3;
    int g_state = 0, g_t = 0, g_cnt = 0;
    logic [15:0] g_words [0:5*N_A-1];
    always @(negedge pixel_clk) begin
        if (bus_a.gpu_reset) begin
            g_state = G_RESET;
            g_cnt   = 0;
        end else if (bus_a.gpu_copy_start) begin
            g_state = G_LOAD;
            g_t     = cyc;
        end else if (g_state == G_LOAD && cyc - g_t >= 2 && (cyc - g_t - 2) % 6 < 5) begin
            g_words[g_cnt] = bus_a.gpu_mem_din;
            g_cnt++;
            if (g_cnt == 5 * N_A) g_state = G_EXEC;
        end
    end

    // Event capture for latency, wrap and done-count checks.
    bit cap1 = 1'b0, capb = 1'b0, dcnt_en = 1'b0;
    int fs_cyc = 0, grst_cyc = -1, st_cyc = -1, rd_cyc = -1, dn_cyc = -1, dcnt = 0;
    int qb[$];
    always @(negedge pixel_clk) begin
        if (cap1) begin
            if (bus_a.gpu_reset && grst_cyc < 0) grst_cyc = cyc;
            if (bus_a.gpu_copy_start && st_cyc < 0) st_cyc = cyc;
            if (bus_a.mem_rd && rd_cyc < 0) rd_cyc = cyc;
            if (done_a && dn_cyc < 0) dn_cyc = cyc;
        end
        if (capb && bus_b.mem_rd) qb.push_back(32'(bus_b.mem_addr));
        if (dcnt_en && done_a) dcnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    initial begin
        int p;
        #1 reset = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(3);

        // Baseline copy: latencies, gpu load contents, wrapped addresses on dut_b.
        cap1 = 1'b1; capb = 1'b1;
        fs_cyc = cyc;
        pulse();
        wait_until(fs_cyc + 400);
        cap1 = 1'b0; capb = 1'b0;
        chk("lat_gpu_reset", 32'(grst_cyc - fs_cyc), 1);
        chk("lat_copy_start", 32'(st_cyc - fs_cyc), 2);
        chk("lat_first_rd", 32'(rd_cyc - fs_cyc), 3);
        chk("lat_done", 32'(dn_cyc - fs_cyc), 387);
        chk("gpu_state", 32'(g_state), G_EXEC);
        chk("rect63_right",
            32'(g_words[63*5+gpu_ctrl_pkg::W_X]) + 32'(g_words[63*5+gpu_ctrl_pkg::W_W]),
            32'(BASE_A + 63*5 + gpu_ctrl_pkg::W_X) + 32'(BASE_A + 63*5 + gpu_ctrl_pkg::W_W));
        chk("b_read_count", 32'(qb.size()), 5 * N_B);
        if (qb.size() >= 3) begin
            chk("b_addr0", 32'(qb[0]), 32'h1FFE);
            chk("b_addr2_wrap", 32'(qb[2]), 32'h0000);
        end

        // Overrun: pulses at copy cycle 200 and in the FINISH cycle.
        p = cyc;
        dcnt = 0; dcnt_en = 1'b1;
        pulse();
        wait_until(p + 2 + 200);
        pulse();
        wait_until(p + 2 + 6 * N_A + 1);
        pulse();
        wait_until(p + 400);
        dcnt_en = 1'b0;
        chk("done_pulses", 32'(dcnt), 1);
        chk("overrun_sticky", 32'(ovr_a), 1);

        // Asynchronous abort mid-copy, then a fresh copy.
        p = cyc;
        pulse();
        wait_until(p + 2 + 100);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_gpu_reset", 32'(bus_a.gpu_reset), 1);
        chk("abort_overrun", 32'(ovr_a), 0);
        chk("abort_mem_rd", 32'(bus_a.mem_rd), 0);
        tick(3);
        reset = 1'b1;
        tick(2);
        p = cyc;
        pulse();
        wait_until(p + 400);

        // Back-to-back frames 400 cycles apart.
        p = cyc;
        pulse();
        wait_until(p + 400);
        pulse();
        wait_until(p + 800);
        chk("no_overrun", 32'(ovr_a), 0);

        // Random frame_start spacing, including overlapping pulses.
        repeat (8) begin
            tick($urandom_range(1, 450));
            pulse();
        end
        tick(400);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
